imem_loader: RTL and testbench

- Boot-time loader and fetch-port controller for the 1024x32 instruction memory, which has a synchronous write port (data/wraddress/wren) and a separate read port (rdaddress/q).
- Accepts a byte stream with a valid/ready handshake and packs the bytes big-endian into 32-bit words.
- Writes each word to consecutive memory addresses starting at 0.
- Holds the CPU stalled until the image is loaded, then passes the CPU PC through to the read port.

---
 rtl/imem_pkg.sv | 16 +
 rtl/byte_packer.sv | 42 ++++
 rtl/imem_loader.sv | 137 +++++++++++++
 tb/tb_imem_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the memory geometry constants.
package imem_pkg;

    localparam int IMEM_ADDR_W    = 10;
    localparam int IMEM_DEPTH     = 1024;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSEMBLE = 2'd1,
        WRITE    = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte packer: shifts accepted bytes into a 32-bit word and flags
// the cycle in which the last byte of a word is accepted. word_next is the
// word as it will look after the current byte, so the loader can capture a
// complete word on the same edge that accepts its final byte.
module byte_packer
    import imem_pkg::*;
#(
    parameter int BYTE_W = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             accept,
    input  logic [BYTE_W-1:0]                in_data,
    output logic [BYTES_PER_WORD*BYTE_W-1:0] word_next,
    output logic                             word_valid
);

    localparam int         WORD_W = BYTES_PER_WORD * BYTE_W;
    localparam logic [1:0] LAST   = 2'(BYTES_PER_WORD - 1);

    logic [WORD_W-1:0] word;
    logic [1:0]        byte_cnt;

    assign word_next  = {word[WORD_W-BYTE_W-1:0], in_data};
    assign word_valid = accept && (byte_cnt == LAST);

    // Shift register and byte counter; the counter wraps after the last byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (accept) begin
            word     <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader for the 1024x32 instruction memory. Streams bytes in,
// writes packed words to consecutive addresses from 0, keeps the CPU stalled
// until the image is complete, then forwards the CPU PC to the read port.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int BYTE_W = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [ADDR_W:0]                  load_len,
    input  logic                             in_valid,
    input  logic [BYTE_W-1:0]                in_data,
    output logic                             in_ready,
    output logic [BYTES_PER_WORD*BYTE_W-1:0] mem_data,
    output logic [ADDR_W-1:0]                mem_wraddress,
    output logic                             mem_wren,
    input  logic [31:0]                      cpu_pc,
    output logic [ADDR_W-1:0]                mem_rdaddress,
    output logic                             cpu_run,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [ADDR_W:0]                  words_loaded
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W + 1)'(1);

    state_t                             state;
    logic [ADDR_W:0]                    len;
    logic [ADDR_W-1:0]                  word_addr;
    logic [BYTES_PER_WORD*BYTE_W-1:0]   word_next;
    logic                               word_valid;
    logic                               can_start;
    logic                               len_zero;
    logic                               len_bad;
    logic                               load_go;
    logic                               unused_pc;

    // A start is honoured only when idle or finished; a legal non-zero
    // length begins a load and also resets the packer.
    assign can_start = start && ((state == IDLE) || (state == DONE));
    assign len_zero  = (load_len == '0);
    assign len_bad   = (load_len > DEPTH);
    assign load_go   = can_start && !len_zero && !len_bad;

    // Read port: word address from the byte PC, forced to 0 while stalled.
    assign mem_rdaddress = cpu_run ? cpu_pc[ADDR_W+1:2] : '0;
    assign unused_pc     = ^{cpu_pc[31:ADDR_W+2], cpu_pc[1:0]};

    byte_packer #(
        .BYTE_W (BYTE_W)
    ) u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (load_go),
        .accept     (in_valid && in_ready),
        .in_data    (in_data),
        .word_next  (word_next),
        .word_valid (word_valid)
    );

    // Load FSM with registered outputs; write strobes last exactly one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            len           <= '0;
            word_addr     <= '0;
            in_ready      <= 1'b0;
            mem_data      <= '0;
            mem_wraddress <= '0;
            mem_wren      <= 1'b0;
            cpu_run       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_loaded  <= '0;
        end else begin
            mem_wren      <= 1'b0;
            mem_data      <= '0;
            mem_wraddress <= '0;
            case (state)
                IDLE, DONE: begin
                    if (can_start) begin
                        if (len_zero) begin
                            state        <= DONE;
                            done         <= 1'b1;
                            cpu_run      <= 1'b1;
                            error        <= 1'b0;
                            words_loaded <= '0;
                        end else if (len_bad) begin
                            // Illegal length: flag it, keep the current state.
                            error <= 1'b1;
                        end else begin
                            state        <= ASSEMBLE;
                            len          <= load_len;
                            word_addr    <= '0;
                            words_loaded <= '0;
                            error        <= 1'b0;
                            in_ready     <= 1'b1;
                            busy         <= 1'b1;
                            done         <= 1'b0;
                            cpu_run      <= 1'b0;
                        end
                    end
                end
                ASSEMBLE: begin
                    if (word_valid) begin
                        state         <= WRITE;
                        in_ready      <= 1'b0;
                        mem_wren      <= 1'b1;
                        mem_wraddress <= word_addr;
                        mem_data      <= word_next;
                    end
                end
                WRITE: begin
                    word_addr    <= word_addr + 1'b1;
                    words_loaded <= words_loaded + ONE;
                    if ((words_loaded + ONE) == len) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cpu_run <= 1'b1;
                    end else begin
                        state    <= ASSEMBLE;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard and memory model.
module tb_imem_loader;
    import imem_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] load_len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] mem_data;
    logic [9:0]  mem_wraddress;
    logic        mem_wren;
    logic [31:0] cpu_pc;
    logic [9:0]  mem_rdaddress;
    logic        cpu_run;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] words_loaded;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          wr_count = 0;
    int          acc_count = 0;
    int          last_wr_addr = -1;
    logic        prev_wren = 1'b0;
    logic [41:0] exp_q[$];
    int          wr_cycs[$];
    logic [31:0] mem_model [IMEM_DEPTH];

    imem_loader dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .load_len      (load_len),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .mem_data      (mem_data),
        .mem_wraddress (mem_wraddress),
        .mem_wren      (mem_wren),
        .cpu_pc        (cpu_pc),
        .mem_rdaddress (mem_rdaddress),
        .cpu_run       (cpu_run),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_loaded  (words_loaded)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycle counter and accepted-byte counter (pre-edge values).
    always @(posedge clock) begin
        cyc++;
        if (in_valid === 1'b1 && in_ready === 1'b1) acc_count++;
    end

    // Write monitor: compare each memory write against the scoreboard.
    always @(negedge clock) begin
        if (mem_wren === 1'b1) begin
            logic [41:0] e;
            wr_count++;
            wr_cycs.push_back(cyc);
            last_wr_addr = int'(mem_wraddress);
            mem_model[mem_wraddress] = mem_data;
            chk("wren_single_cycle", 64'(prev_wren), 64'(0));
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(mem_wren), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 64'(mem_wraddress), 64'(e[41:32]));
                chk("write_data", 64'(mem_data), 64'(e[31:0]));
            end
        end
        prev_wren = mem_wren;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic do_start(input logic [10:0] n);
        start    = 1'b1;
        load_len = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("send_ready", 64'(in_ready), 64'(1));
        tick();
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk(tag, 64'(done), 64'(1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  t1_bytes [8];
        logic [31:0] w;
        int          wc0;
        int          ac0;
        int          rdy_seen;

        t1_bytes = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
        reset = 1'b1; start = 1'b0; load_len = '0;
        in_valid = 1'b0; in_data = '0; cpu_pc = 32'h40;
        tick(); tick();

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_cpu_run", 64'(cpu_run), 64'(0));
        chk("rst_error", 64'(error), 64'(0));
        chk("rst_wren", 64'(mem_wren), 64'(0));
        chk("rst_words", 64'(words_loaded), 64'(0));
        chk("rst_rdaddr", 64'(mem_rdaddress), 64'(0));
        reset = 1'b0;
        tick();

        // Test 1: two-word load, in_valid always high
        exp_q.push_back({10'd0, 32'h8C010004});
        exp_q.push_back({10'd1, 32'hAC020008});
        do_start(11'd2);
        chk("t1_busy", 64'(busy), 64'(1));
        chk("t1_in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 8; i++) send_byte(t1_bytes[i]);
        in_valid = 1'b0;
        wait_done("t1_done", 20);
        chk("t1_cpu_run", 64'(cpu_run), 64'(1));
        chk("t1_busy_low", 64'(busy), 64'(0));
        chk("t1_words", 64'(words_loaded), 64'(2));
        chk("t1_wr_count", 64'(wr_count), 64'(2));
        chk("t1_wr_gap", 64'(wr_cycs[1] - wr_cycs[0]), 64'(5));
        chk("t1_mem0", 64'(mem_model[0]), 64'(32'h8C010004));
        chk("t1_mem1", 64'(mem_model[1]), 64'(32'hAC020008));
        chk("t1_rdaddr", 64'(mem_rdaddress), 64'(16));

        // Test 2a: zero-length load goes straight to DONE
        do_reset();
        wc0 = wr_count;
        do_start(11'd0);
        chk("t2_done", 64'(done), 64'(1));
        chk("t2_cpu_run", 64'(cpu_run), 64'(1));
        chk("t2_error", 64'(error), 64'(0));
        tick(); tick();
        chk("t2_no_write", 64'(wr_count), 64'(wc0));

        // Test 2b: over-length load is rejected
        do_reset();
        do_start(11'd1025);
        chk("t2_err", 64'(error), 64'(1));
        chk("t2_err_busy", 64'(busy), 64'(0));
        rdy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (in_ready === 1'b1) rdy_seen++;
            tick();
        end
        chk("t2_ready_never", 64'(rdy_seen), 64'(0));
        chk("t2_err_sticky", 64'(error), 64'(1));
        chk("t2_not_done", 64'(done), 64'(0));

        // Test 3: one word with gaps and a byte held during WRITE
        exp_q.push_back({10'd0, 32'hDEADBEEF});
        ac0 = acc_count;
        do_start(11'd1);
        chk("t3_err_clear", 64'(error), 64'(0));
        send_byte(8'hDE); in_valid = 1'b0; tick();
        send_byte(8'hAD); in_valid = 1'b0; tick();
        send_byte(8'hBE); in_valid = 1'b0; tick();
        send_byte(8'hEF);
        in_data = 8'hEE;
        chk("t3_ready_in_write", 64'(in_ready), 64'(0));
        chk("t3_wren", 64'(mem_wren), 64'(1));
        tick();
        chk("t3_done", 64'(done), 64'(1));
        chk("t3_ready_in_done", 64'(in_ready), 64'(0));
        tick();
        in_valid = 1'b0;
        chk("t3_bytes", 64'(acc_count - ac0), 64'(4));
        chk("t3_mem0", 64'(mem_model[0]), 64'(32'hDEADBEEF));

        // Test 4: asynchronous reset after two bytes
        wc0 = wr_count;
        do_start(11'd1);
        send_byte(8'h55);
        send_byte(8'h66);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t4_in_ready", 64'(in_ready), 64'(0));
        chk("t4_busy", 64'(busy), 64'(0));
        chk("t4_done", 64'(done), 64'(0));
        chk("t4_cpu_run", 64'(cpu_run), 64'(0));
        chk("t4_wren", 64'(mem_wren), 64'(0));
        chk("t4_words", 64'(words_loaded), 64'(0));
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("t4_no_write", 64'(wr_count), 64'(wc0));
        exp_q.push_back({10'd0, 32'h01020304});
        do_start(11'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        in_valid = 1'b0;
        wait_done("t4_done_after", 20);
        chk("t4_mem0", 64'(mem_model[0]), 64'(32'h01020304));

        // Test 5: full 1024-word load
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            w = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
            exp_q.push_back({10'(i), w});
        end
        do_start(11'd1024);
        for (int k = 0; k < 4 * IMEM_DEPTH; k++) send_byte(8'(k));
        in_valid = 1'b0;
        wait_done("t5_done", 20);
        chk("t5_words", 64'(words_loaded), 64'(1024));
        chk("t5_last_addr", 64'(last_wr_addr), 64'(1023));
        chk("t5_queue_empty", 64'(exp_q.size()), 64'(0));
        chk("t5_mem1023", 64'(mem_model[1023]), 64'(32'hFCFDFEFF));
        cpu_pc = 32'h00000FFC; #1;
        chk("t5_rd_ffc", 64'(mem_rdaddress), 64'(1023));
        cpu_pc = 32'h00001000; #1;
        chk("t5_rd_1000", 64'(mem_rdaddress), 64'(0));
        cpu_pc = 32'h00000007; #1;
        chk("t5_rd_lowbits", 64'(mem_rdaddress), 64'(1));

        // Test 6: reload from DONE
        cpu_pc = 32'h00000FFC;
        exp_q.push_back({10'd0, 32'hCAFEF00D});
        do_start(11'd1);
        chk("t6_cpu_run_drop", 64'(cpu_run), 64'(0));
        chk("t6_done_drop", 64'(done), 64'(0));
        chk("t6_rdaddr", 64'(mem_rdaddress), 64'(0));
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
        in_valid = 1'b0;
        wait_done("t6_done", 20);
        chk("t6_cpu_run", 64'(cpu_run), 64'(1));
        chk("t6_rdaddr_run", 64'(mem_rdaddress), 64'(1023));
        chk("t6_words", 64'(words_loaded), 64'(1));
        chk("t6_mem0", 64'(mem_model[0]), 64'(32'hCAFEF00D));
        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
